ex_muldiv_unit: RTL and testbench
=================================

# ex_muldiv_unit

Iterative RV32M multiply/divide unit in the EX stage. It consumes the operand values and control latched by the ID/EX pipeline barrier. It runs one radix-2 step per cycle and asserts a stall so that the PC, IF/ID and ID/EX barriers hold while it works. It delivers a 32-bit result to the EX/MEM path with a one-cycle done pulse.

## Interface
- XLEN, 32: operand/result width; only 32 is supported.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request from EX control (M-extension instruction present in EX)
- op  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- lhs  in  XLEN  rs1 value (post-forwarding)
- rhs  in  XLEN  rs2 value (post-forwarding)
- flush  in  1  branch/exception kill of the EX instruction
- stall  out  1  freeze upstream barriers
- done  out  1  result valid, one-cycle pulse
- result  out  XLEN  final value; held until next accepted start

## Operation
- States:
  - IDLE: waiting for a request.
  - MUL: iterating a multiply.
  - DIV: iterating a divide.
  - DONE: presenting the result.
- IDLE, start=1, flush=0: latch op.
  - Latch |lhs| and |rhs|; signedness comes from op (MULH: both signed; MULHSU: lhs only; DIV/REM: both; others unsigned).
  - Latch the negate-result flag.
  - Clear the 64-bit accumulator and the 5-bit step counter.
  - Next state is MUL or DIV.
- Fast path, IDLE → DONE directly:
  - rhs=0 on DIV/DIVU: result 0xFFFF_FFFF.
  - rhs=0 on REM/REMU: result lhs.
  - Signed overflow, DIV with lhs=0x8000_0000 and rhs=0xFFFF_FFFF: result 0x8000_0000.
  - Signed overflow, REM with the same operands: result 0.
- MUL: shift-add, one multiplier bit per cycle, 32 steps.
  - Final 64-bit product is conditionally negated.
  - MUL returns bits [31:0]; the MULH variants return bits [63:32].
- DIV: restoring shift-subtract, 32 steps, yielding quotient and remainder.
  - Quotient is negated when operand signs differ.
  - Remainder takes the sign of lhs.
- Counter at 31 during MUL/DIV: register result, go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- start while in MUL/DIV/DONE: ignored (upstream is stalled, so it is the same instruction held).
- flush in any state: next state IDLE, no done, result unchanged.
- flush and start in the same IDLE cycle: flush wins.

## Timing
- Reset values: state IDLE, stall 0, done 0, result 0, counter 0, accumulator 0.
- stall is combinational.
  - High in IDLE when start & ~flush & not fast-path.
  - High in MUL and DIV.
  - Low in IDLE otherwise and in DONE.
- Iterative latency: start sampled at edge N; done=1 in the cycle after edge N+32 (33 cycles).
- Fast-path latency: done=1 in the cycle after edge N (1 cycle); stall stays low.
- Back-to-back: a new start is accepted in the IDLE cycle after DONE.
- Asynchronous reset mid-operation: immediate return to IDLE with all outputs at reset values.

## Configuration
- MULDIV_DIV_EN defined: full M extension as described.
- MULDIV_DIV_EN undefined:
  - Divider datapath and DIV state are compiled out.
  - Ops 4–7 take the fast path with result 0, done after 1 cycle, stall never asserted.
  - Multiply is unchanged.

## Structure
- Shared package muldiv_pkg:
  - op encodings MULDIV_MUL … MULDIV_REMU
  - state enum (IDLE, MUL, DIV, DONE)
  - constants XLEN_MIN (0x8000_0000) and ALL_ONES
- One sub-module, muldiv_negate: parameterised-width conditional two's-complement.
  - Instantiated for operand absolute values, the product and the quotient/remainder.

## Test plan
- MUL lhs=7, rhs=0xFFFF_FFFD (−3) → result 0xFFFF_FFEB; done exactly 33 cycles after start; stall high 32 cycles.
- MULHU lhs=rhs=0xFFFF_FFFF → 0xFFFF_FFFE. MULH same operands → 0x0000_0000. MULHSU lhs=0xFFFF_FFFF, rhs=2 → 0xFFFF_FFFF.
- DIV 20/0 → 0xFFFF_FFFF and REMU 20/0 → 20 (0x14), each done 1 cycle after start with stall low.
- DIV 0x8000_0000/0xFFFF_FFFF → 0x8000_0000; REM same operands → 0; REM −7/2 → 0xFFFF_FFFF; DIVU 100/7 → 14 (0xE).
- Flush on cycle 10 of a DIV → no done pulse, stall low next cycle, result keeps its previous value; following MUL 6×7 → 42 (0x2A).
- rst_n low on cycle 15 of a MUL → stall/done/result 0 immediately; after release, start MUL 3×5 → 15 (0xF) after 33 cycles.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the EX-stage RV32M multiply/divide unit.
package muldiv_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [2:0] {
        MULDIV_MUL    = 3'd0,
        MULDIV_MULH   = 3'd1,
        MULDIV_MULHSU = 3'd2,
        MULDIV_MULHU  = 3'd3,
        MULDIV_DIV    = 3'd4,
        MULDIV_DIVU   = 3'd5,
        MULDIV_REM    = 3'd6,
        MULDIV_REMU   = 3'd7
    } muldivOp_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StMul  = 2'd1,
        StDiv  = 2'd2,
        StDone = 2'd3
    } muldivState_e;

    localparam logic [XLEN-1:0] XLEN_MIN = 32'h8000_0000;
    localparam logic [XLEN-1:0] ALL_ONES = 32'hFFFF_FFFF;

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement negation of a Width-bit value.
module muldiv_negate #(
    parameter int unsigned Width = 32
) (
    input  logic             neg,
    input  logic [Width-1:0] dataIn,
    output logic [Width-1:0] dataOut
);

    assign dataOut = neg ? (~dataIn + {{(Width-1){1'b0}}, 1'b1}) : dataIn;

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage, one radix-2 step per cycle.
// Define MULDIV_DIV_EN to build the divider; otherwise divide ops complete at once with 0.
module ex_muldiv_unit
    import muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] lhs,
    input  logic [XLEN-1:0] rhs,
    input  logic            flush,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);

    muldivState_e    state;
    logic [2:0]      opQ;
    logic [XLEN-1:0] aQ;
    logic [XLEN-1:0] bQ;
    logic            negQ;
    logic [63:0]     acc;
    logic [4:0]      cnt;
    logic            doneQ;

    logic            lhsNeg;
    logic            rhsNeg;
    logic            negFlag;
    logic [XLEN-1:0] absLhs;
    logic [XLEN-1:0] absRhs;
    logic            fastPath;
    logic [XLEN-1:0] fastResult;
    logic [63:0]     accNext;
    logic [63:0]     prodVal;
    logic [XLEN-1:0] mulResult;

    always_comb begin
        lhsNeg = lhs[XLEN-1] && ((op == MULDIV_MULH) || (op == MULDIV_MULHSU) ||
                                 (op == MULDIV_DIV)  || (op == MULDIV_REM));
        rhsNeg = rhs[XLEN-1] && ((op == MULDIV_MULH) || (op == MULDIV_DIV) ||
                                 (op == MULDIV_REM));
        // Remainder follows the dividend's sign; everything else follows the sign product.
        negFlag = (op[2] && op[1]) ? lhsNeg : (lhsNeg ^ rhsNeg);
    end

    muldiv_negate #(.Width(XLEN)) uAbsLhs (.neg(lhsNeg), .dataIn(lhs), .dataOut(absLhs));
    muldiv_negate #(.Width(XLEN)) uAbsRhs (.neg(rhsNeg), .dataIn(rhs), .dataOut(absRhs));

    always_comb begin
`ifdef MULDIV_DIV_EN
        logic divZero;
        logic sOvf;
        divZero  = (rhs == '0);
        sOvf     = ((op == MULDIV_DIV) || (op == MULDIV_REM)) &&
                   (lhs == XLEN_MIN) && (rhs == ALL_ONES);
        fastPath = op[2] && (divZero || sOvf);
        if (divZero) begin
            fastResult = op[1] ? lhs : ALL_ONES;
        end else begin
            fastResult = op[1] ? '0 : XLEN_MIN;
        end
`else
        fastPath   = op[2];
        fastResult = '0;
`endif
    end

    assign stall = ((state == StIdle) && start && !flush && !fastPath) ||
                   (state == StMul) || (state == StDiv);
    assign done  = doneQ;

`ifdef MULDIV_DIV_EN
    logic [32:0]     remShift;
    logic [33:0]     diff;
    logic            qBit;
    logic [XLEN-1:0] divSel;
    logic [XLEN-1:0] divResult;

    // acc holds {partial remainder, quotient}; dividend bits are taken MSB-first from aQ.
    always_comb begin
        remShift = {acc[63:32], aQ[5'd31 - cnt]};
        diff     = {1'b0, remShift} - {2'b00, bQ};
        qBit     = !diff[33];
    end
`endif

    always_comb begin
        accNext = acc;
        if (state == StMul) begin
            accNext = acc + (aQ[cnt] ? ({32'b0, bQ} << cnt) : 64'b0);
        end
`ifdef MULDIV_DIV_EN
        if (state == StDiv) begin
            accNext = {(qBit ? diff[31:0] : remShift[31:0]), acc[30:0], qBit};
        end
`endif
    end

    muldiv_negate #(.Width(64)) uNegProd (.neg(negQ), .dataIn(accNext), .dataOut(prodVal));
    assign mulResult = (opQ == MULDIV_MUL) ? prodVal[31:0] : prodVal[63:32];

`ifdef MULDIV_DIV_EN
    assign divSel = opQ[1] ? accNext[63:32] : accNext[31:0];
    muldiv_negate #(.Width(XLEN)) uNegDiv (.neg(negQ), .dataIn(divSel), .dataOut(divResult));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= StIdle;
            opQ    <= 3'd0;
            aQ     <= '0;
            bQ     <= '0;
            negQ   <= 1'b0;
            acc    <= '0;
            cnt    <= '0;
            result <= '0;
            doneQ  <= 1'b0;
        end else begin
            doneQ <= 1'b0;
            if (flush) begin
                state <= StIdle;
            end else begin
                unique case (state)
                    StIdle: begin
                        if (start) begin
                            if (fastPath) begin
                                result <= fastResult;
                                doneQ  <= 1'b1;
                                state  <= StDone;
                            end else begin
                                opQ   <= op;
                                aQ    <= absLhs;
                                bQ    <= absRhs;
                                negQ  <= negFlag;
                                acc   <= '0;
                                cnt   <= '0;
`ifdef MULDIV_DIV_EN
                                state <= op[2] ? StDiv : StMul;
`else
                                state <= StMul;
`endif
                            end
                        end
                    end
                    StMul: begin
                        acc <= accNext;
                        cnt <= cnt + 5'd1;
                        if (cnt == 5'd31) begin
                            result <= mulResult;
                            doneQ  <= 1'b1;
                            state  <= StDone;
                        end
                    end
`ifdef MULDIV_DIV_EN
                    StDiv: begin
                        acc <= accNext;
                        cnt <= cnt + 5'd1;
                        if (cnt == 5'd31) begin
                            result <= divResult;
                            doneQ  <= 1'b1;
                            state  <= StDone;
                        end
                    end
`endif
                    StDone: state <= StIdle;
                    default: state <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed plan plus randomized ops against a
// 64-bit arithmetic reference model.
module tb_ex_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] lhs;
    logic [31:0] rhs;
    logic        flush;
    logic        stall;
    logic        done;
    logic [31:0] result;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ex_muldiv_unit dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .lhs    (lhs),
        .rhs    (rhs),
        .flush  (flush),
        .stall  (stall),
        .done   (done),
        .result (result)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] refModel(input logic [2:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        p  = '0;
`ifndef MULDIV_DIV_EN
        if (o[2]) return 32'h0;
`endif
        case (o)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
            3'd5: begin if (b == 0) return 32'hFFFF_FFFF; p = ua / ub; return p[31:0]; end
            3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
            default: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
        endcase
    endfunction

    function automatic bit isFast(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_DIV_EN
        return o[2] && ((b == 0) ||
               ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
`else
        return o[2] && (a == a) && (b == b);
`endif
    endfunction

    task automatic doOp(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
        logic [31:0] exp;
        bit fast;
        int cyc;
        int stallCnt;
        exp = refModel(o, a, b);
        fast = isFast(o, a, b);
        cyc = 1;
        stallCnt = 0;
        @(negedge clk);
        start = 1'b1; op = o; lhs = a; rhs = b;
        #1 check({tag, "/stall_req"}, 32'(stall), 32'(fast ? 0 : 1));
        @(posedge clk);
        #1;
        start = 1'b0; op = 3'($urandom); lhs = $urandom; rhs = $urandom;
        while (done !== 1'b1 && cyc < 100) begin
            if (stall === 1'b1) stallCnt++;
            @(posedge clk);
            #1;
            cyc++;
        end
        check({tag, "/latency"}, 32'(cyc), 32'(fast ? 1 : 33));
        check({tag, "/stall_cycles"}, 32'(stallCnt), 32'(fast ? 0 : 32));
        check({tag, "/result"}, result, exp);
        @(posedge clk);
        #1;
        check({tag, "/done_pulse"}, 32'(done), 32'd0);
        check({tag, "/result_hold"}, result, exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] prev;
        int doneSeen;
        logic [2:0] flushOp;
        logic [2:0] ro;
        logic [31:0] ra, rb;

        rst_n = 1'b0; start = 1'b0; op = 3'd0; lhs = '0; rhs = '0; flush = 1'b0;
        #12;
        check("reset/stall", 32'(stall), 32'd0);
        check("reset/done", 32'(done), 32'd0);
        check("reset/result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        doOp(3'd0, 32'd7, 32'hFFFF_FFFD, "mul_7_m3");
        doOp(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_ones");
        doOp(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulh_ones");
        doOp(3'd2, 32'hFFFF_FFFF, 32'd2, "mulhsu_m1_2");
        doOp(3'd4, 32'd20, 32'd0, "div_by_zero");
        doOp(3'd7, 32'd20, 32'd0, "remu_by_zero");
        doOp(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        doOp(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
        doOp(3'd6, 32'hFFFF_FFF9, 32'd2, "rem_m7_2");
        doOp(3'd5, 32'd100, 32'd7, "divu_100_7");

        // Kill an in-flight iterative op on its tenth cycle.
`ifdef MULDIV_DIV_EN
        flushOp = 3'd4;
`else
        flushOp = 3'd0;
`endif
        prev = result;
        @(negedge clk);
        start = 1'b1; op = flushOp; lhs = 32'd1000; rhs = 32'd7;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        check("flush/stall", 32'(stall), 32'd0);
        check("flush/done", 32'(done), 32'd0);
        check("flush/result", result, prev);
        doneSeen = 0;
        repeat (40) begin
            @(posedge clk);
            #1 if (done === 1'b1) doneSeen++;
        end
        check("flush/no_done", 32'(doneSeen), 32'd0);
        doOp(3'd0, 32'd6, 32'd7, "mul_after_flush");

        // Asynchronous reset in the middle of a multiply.
        @(negedge clk);
        start = 1'b1; op = 3'd0; lhs = 32'd9; rhs = 32'd11;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (14) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("areset/stall", 32'(stall), 32'd0);
        check("areset/done", 32'(done), 32'd0);
        check("areset/result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        doOp(3'd0, 32'd3, 32'd5, "mul_after_reset");

        for (int i = 0; i < 30; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 15));
                3: ra = 32'hFFFF_FFFF;
                default: ;
            endcase
            doOp(ro, ra, rb, $sformatf("rand%0d_op%0d", i, ro));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
